// File: rtl/aoi21_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aoi21_pipe_pkg
// Brief    : Shared mode encodings and evaluation helpers for aoi21_pipe_bank.
// Revision : 1.0 - initial release
// ============================================================================
package aoi21_pipe_pkg;

    localparam logic MODE_AOI21 = 1'b0;
    localparam logic MODE_OAI21 = 1'b1;

    // Widest slice count supported by the bank; popcount works on this width.
    localparam int c_MAX_WIDTH = 64;
    localparam int c_POP_W     = 7;

    function automatic logic aoi_eval(input logic mode, input logic a,
                                      input logic b1, input logic b2);
        logic res;
        case (mode)
            MODE_AOI21: res = ~(a | (b1 & b2));
            default:    res = ~(a & (b1 | b2));
        endcase
        return res;
    endfunction

    function automatic logic [c_POP_W-1:0] popcount(input logic [c_MAX_WIDTH-1:0] vec);
        logic [c_POP_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < c_MAX_WIDTH; i++) begin
            cnt = cnt + {{(c_POP_W-1){1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aoi21_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : aoi21_pipe_stage
// Brief    : One elastic valid/ready register stage, async active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module aoi21_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             w_load;

    // Accept when empty or when the held word leaves this same cycle.
    assign o_ready = ~r_valid | i_ready;
    assign w_load  = i_valid & o_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/aoi21_pipe_bank.sv
`default_nettype none
// ============================================================================
// Module   : aoi21_pipe_bank
// Brief    : WIDTH-slice AOI21/OAI21 bank behind an elastic pipeline, with a
//            saturating output-toggle counter.
// Revision : 1.0 - initial release
// ============================================================================
module aoi21_pipe_bank #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             CK,
    input  logic             RN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B1,
    input  logic [WIDTH-1:0] B2,
    input  logic             MODE,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] ZN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    input  logic             TGL_CLR,
    output logic [CNT_W-1:0] TGL_CNT
);

    import aoi21_pipe_pkg::*;

    localparam int             c_SUM_W   = 40;
    localparam logic [c_SUM_W-1:0] c_CNT_MAX = (40'd1 << CNT_W) - 40'd1;

    logic [WIDTH-1:0] w_eval;
    logic [WIDTH-1:0] w_data  [STAGES+1];
    logic             w_valid [STAGES+1];
    logic             w_ready [STAGES+1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        assign w_eval[i] = aoi_eval(MODE, A[i], B1[i], B2[i]);
    end

    assign w_data[0]       = w_eval;
    assign w_valid[0]      = IN_VALID;
    assign w_ready[STAGES] = OUT_READY;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        aoi21_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .i_clk   (CK),
            .i_rst_n (RN),
            .i_data  (w_data[s]),
            .i_valid (w_valid[s]),
            .o_ready (w_ready[s]),
            .o_data  (w_data[s+1]),
            .o_valid (w_valid[s+1]),
            .i_ready (w_ready[s+1])
        );
    end

    assign IN_READY  = w_ready[0];
    assign ZN        = w_data[STAGES];
    assign OUT_VALID = w_valid[STAGES];

    logic [WIDTH-1:0]       r_prev;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_out_hs;
    logic [c_MAX_WIDTH-1:0] w_diff;
    logic [c_SUM_W-1:0]     w_sum;
    logic [CNT_W-1:0]       w_cnt_next;

    assign w_out_hs = OUT_VALID & OUT_READY;

    // Sum is formed wide enough that any overflow of CNT_W is visible.
    always_comb begin
        w_diff             = '0;
        w_diff[WIDTH-1:0]  = ZN ^ r_prev;
        w_sum              = '0;
        w_sum[CNT_W-1:0]   = r_cnt;
        w_sum              = w_sum + {{(c_SUM_W-c_POP_W){1'b0}}, popcount(w_diff)};
        w_cnt_next         = (w_sum > c_CNT_MAX) ? c_CNT_MAX[CNT_W-1:0] : w_sum[CNT_W-1:0];
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_prev <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_out_hs) begin
                r_prev <= ZN;
            end
            if (TGL_CLR) begin
                r_cnt <= '0;
            end else if (w_out_hs) begin
                r_cnt <= w_cnt_next;
            end
        end
    end

    assign TGL_CNT = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_aoi21_pipe_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_aoi21_pipe_bank
// Brief    : Directed self-checking bench for aoi21_pipe_bank (CNT_W 16 and 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aoi21_pipe_bank;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic        CK;
    logic        RN;
    logic [7:0]  A, B1, B2;
    logic        MODE;
    logic        IN_VALID;
    logic        IN_READY, IN_READY_S;
    logic [7:0]  ZN, ZN_S;
    logic        OUT_VALID, OUT_VALID_S;
    logic        OUT_READY;
    logic        TGL_CLR;
    logic [15:0] TGL_CNT;
    logic [2:0]  TGL_CNT_S;

    int total;
    int bad;

    aoi21_pipe_bank #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(16)) u_dut (
        .CK(CK), .RN(RN), .A(A), .B1(B1), .B2(B2), .MODE(MODE),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .ZN(ZN), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .TGL_CLR(TGL_CLR), .TGL_CNT(TGL_CNT)
    );

    aoi21_pipe_bank #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(3)) u_dut_sat (
        .CK(CK), .RN(RN), .A(A), .B1(B1), .B2(B2), .MODE(MODE),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY_S), .ZN(ZN_S), .OUT_VALID(OUT_VALID_S),
        .OUT_READY(OUT_READY), .TGL_CLR(TGL_CLR), .TGL_CNT(TGL_CNT_S)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic drive(input logic m, input logic [7:0] a, input logic [7:0] b1,
                         input logic [7:0] b2, input logic v);
        MODE = m; A = a; B1 = b1; B2 = b2; IN_VALID = v;
    endtask

    initial begin
        total = 0; bad = 0;
        RN = 1'b0; OUT_READY = 1'b1; TGL_CLR = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        #12;
        check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("rst_zn", {24'd0, ZN}, 32'd0);
        check("rst_cnt", {16'd0, TGL_CNT}, 32'd0);
        @(negedge CK);
        RN = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, IN_READY}, 32'd1);

        // Back-to-back words with alternating MODE.
        drive(1'b0, 8'h0F, 8'hF0, 8'h30, 1'b1);
        tick();
        check("lat_not_yet", {31'd0, OUT_VALID}, 32'd0);
        drive(1'b1, 8'h0F, 8'hF0, 8'h30, 1'b1);
        tick();
        check("aoi_valid", {31'd0, OUT_VALID}, 32'd1);
        check("aoi_zn", {24'd0, ZN}, 32'hC0);
        drive(1'b0, 8'h00, 8'hFF, 8'h0F, 1'b1);
        tick();
        check("oai_zn", {24'd0, ZN}, 32'hFF);
        check("cnt_c0", {16'd0, TGL_CNT}, 32'd2);
        check("sat_c0", {29'd0, TGL_CNT_S}, 32'd2);
        drive(1'b1, 8'hFF, 8'h00, 8'h01, 1'b1);
        tick();
        IN_VALID = 1'b0;
        check("w3_zn", {24'd0, ZN}, 32'hF0);
        check("cnt_ff", {16'd0, TGL_CNT}, 32'd8);
        check("sat_ff", {29'd0, TGL_CNT_S}, 32'd7);
        tick();
        check("w4_zn", {24'd0, ZN}, 32'hFE);
        check("cnt_f0", {16'd0, TGL_CNT}, 32'd12);
        tick();
        check("drained", {31'd0, OUT_VALID}, 32'd0);
        check("cnt_fe", {16'd0, TGL_CNT}, 32'd15);
        check("sat_hold", {29'd0, TGL_CNT_S}, 32'd7);

        // Backpressure: two words fill the pipe, third stalls.
        OUT_READY = 1'b0;
        drive(1'b0, 8'hFF, 8'h00, 8'h00, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h0F, 8'h03, 1'b1);
        check("bp_ready2", {31'd0, IN_READY}, 32'd1);
        tick();
        drive(1'b1, 8'hFF, 8'h55, 8'h00, 1'b1);
        check("bp_full", {31'd0, IN_READY}, 32'd0);
        check("bp_zn", {24'd0, ZN}, 32'h00);
        check("bp_valid", {31'd0, OUT_VALID}, 32'd1);
        tick();
        check("bp_hold_zn", {24'd0, ZN}, 32'h00);
        check("bp_hold_ready", {31'd0, IN_READY}, 32'd0);
        OUT_READY = 1'b1;
        #1;
        check("bp_ready_chain", {31'd0, IN_READY}, 32'd1);
        tick();
        IN_VALID = 1'b0;
        check("bp_p2", {24'd0, ZN}, 32'hFC);
        check("bp_cnt1", {16'd0, TGL_CNT}, 32'd22);
        tick();
        check("bp_p3", {24'd0, ZN}, 32'hAA);
        check("bp_cnt2", {16'd0, TGL_CNT}, 32'd28);
        tick();
        check("bp_empty", {31'd0, OUT_VALID}, 32'd0);
        check("bp_cnt3", {16'd0, TGL_CNT}, 32'd32);

        // Clear colliding with an output handshake.
        drive(1'b0, 8'h00, 8'hFF, 8'hFF, 1'b1);
        tick();
        drive(1'b0, 8'hFE, 8'h00, 8'h00, 1'b1);
        tick();
        IN_VALID = 1'b0;
        check("clr_word", {24'd0, ZN}, 32'h00);
        TGL_CLR = 1'b1;
        tick();
        TGL_CLR = 1'b0;
        check("clr_cnt", {16'd0, TGL_CNT}, 32'd0);
        check("clr_sat", {29'd0, TGL_CNT_S}, 32'd0);
        tick();
        check("clr_next", {16'd0, TGL_CNT}, 32'd1);
        check("clr_next_sat", {29'd0, TGL_CNT_S}, 32'd1);

        // Reset with two words in flight.
        OUT_READY = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        tick();
        drive(1'b1, 8'h0F, 8'hF0, 8'h30, 1'b1);
        tick();
        IN_VALID = 1'b0;
        #2;
        RN = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, OUT_VALID}, 32'd0);
        check("mid_rst_zn", {24'd0, ZN}, 32'd0);
        check("mid_rst_cnt", {16'd0, TGL_CNT}, 32'd0);
        @(negedge CK);
        RN = 1'b1;
        OUT_READY = 1'b1;
        tick();
        check("post_rst_ready", {31'd0, IN_READY}, 32'd1);
        check("post_rst_empty", {31'd0, OUT_VALID}, 32'd0);

        // PREV must be zero again after reset.
        drive(1'b0, 8'h0F, 8'hF0, 8'h30, 1'b1);
        tick();
        IN_VALID = 1'b0;
        tick();
        check("post_rst_zn", {24'd0, ZN}, 32'hC0);
        tick();
        check("post_rst_cnt", {16'd0, TGL_CNT}, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
